ahb_lite_master: RTL



---
 rtl/ahb_lite_master.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: command/stream front end to pipelined AHB-Lite SINGLE/INCR bursts with BUSY, wait states and ERROR cancel.
// Optional HREADY-low watchdog enabled by defining AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic              cmd_write_i,
    input  logic [2:0]        cmd_size_i,
    input  logic [4:0]        cmd_len_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              done_o,
    output logic              err_o,
    output logic              timeout_o,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP
);
`ifdef AHB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    typedef enum logic [2:0] {IDLE, ADDR, BURST, LAST_DATA, ERR1, ERR2} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] haddr_n, step;
    logic [1:0]        htrans_n;
    logic              hwrite_n;
    logic [2:0]        hsize_n, hburst_n, csize;
    logic [DATA_W-1:0] hwdata_n, wbuf, wbuf_n, rd_data_n;
    logic [4:0]        clen;
    logic [10:0]       span;
    logic [3:0]        cnt, cnt_n;
    logic [TW-1:0]     wd, wd_n;
    logic              dp, dp_n, wr_take, accept, busy;
    logic              rd_valid_n, rd_last_n, done_n, err_n, timeout_n;

    assign cmd_ready_o = (state == IDLE) && !rst_i;
    assign wr_ready_o  = wr_take && !rst_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign csize       = (cmd_size_i > 3'd2) ? 3'd2 : cmd_size_i;
    assign clen        = (cmd_len_i == 5'd0) ? 5'd1 : (cmd_len_i > 5'd16) ? 5'd16 : cmd_len_i;
    assign span        = {1'b0, cmd_addr_i[9:0]} + (11'(clen) << csize);
    assign step        = ADDR_W'(1) << HSIZE;
    assign busy        = (state == BURST) || (state == LAST_DATA) || (state == ERR2);

    always_comb begin
        state_n    = state;
        haddr_n    = HADDR;
        htrans_n   = HTRANS;
        hwrite_n   = HWRITE;
        hsize_n    = HSIZE;
        hburst_n   = HBURST;
        hwdata_n   = HWDATA;
        wbuf_n     = wbuf;
        cnt_n      = cnt;
        dp_n       = dp;
        rd_valid_n = 1'b0;
        rd_last_n  = 1'b0;
        rd_data_n  = rd_data_o;
        done_n     = 1'b0;
        err_n      = 1'b0;
        timeout_n  = 1'b0;
        wr_take    = 1'b0;
        wd_n       = (TO_EN && busy && !HREADY) ? wd + TW'(1) : '0;
        case (state)
            IDLE: if (accept) begin
                if (span > 11'd1024) begin
                    done_n = 1'b1;
                    err_n  = 1'b1;
                end else begin
                    haddr_n  = cmd_addr_i;
                    hwrite_n = cmd_write_i;
                    hsize_n  = csize;
                    hburst_n = (clen == 5'd1) ? 3'b000 : (clen == 5'd4) ? 3'b011 :
                               (clen == 5'd8) ? 3'b101 : (clen == 5'd16) ? 3'b111 : 3'b001;
                    cnt_n    = 4'(clen - 5'd1);
                    dp_n     = 1'b0;
                    if (!cmd_write_i || wr_valid_i) begin
                        htrans_n = T_NSEQ;
                        wr_take  = cmd_write_i;
                        state_n  = BURST;
                    end else begin
                        state_n = ADDR;
                    end
                end
            end
            ADDR: if (wr_valid_i) begin
                htrans_n = T_NSEQ;
                wr_take  = 1'b1;
                state_n  = BURST;
            end
            BURST, LAST_DATA: begin
                if (dp && HRESP == 2'b01 && !HREADY) begin
                    htrans_n = T_IDLE;
                    state_n  = ERR1;
                end else if (HREADY) begin
                    dp_n = HTRANS[1];
                    if (dp && !HWRITE && HRESP == 2'b00) begin
                        rd_valid_n = 1'b1;
                        rd_data_n  = HRDATA;
                        rd_last_n  = (state == LAST_DATA);
                    end
                    if (state == LAST_DATA) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else if (HTRANS[1]) begin
                        hwdata_n = wbuf;
                        if (cnt == 4'd0) begin
                            htrans_n = T_IDLE;
                            state_n  = LAST_DATA;
                        end else begin
                            haddr_n = HADDR + step;
                            if (!HWRITE || wr_valid_i) begin
                                htrans_n = T_SEQ;
                                cnt_n    = cnt - 4'd1;
                                wr_take  = HWRITE;
                            end else begin
                                htrans_n = T_BUSY;
                            end
                        end
                    end else if (wr_valid_i) begin
                        htrans_n = T_SEQ;
                        cnt_n    = cnt - 4'd1;
                        wr_take  = 1'b1;
                    end
                end
            end
            ERR1: state_n = ERR2;
            ERR2: if (HREADY) begin
                done_n  = 1'b1;
                err_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Watchdog overrides everything, including a pending ERROR sequence
        if (TO_EN && busy && !HREADY && wd == TW'(TIMEOUT_CYC - 1)) begin
            htrans_n   = T_IDLE;
            state_n    = IDLE;
            done_n     = 1'b1;
            err_n      = 1'b1;
            timeout_n  = 1'b1;
            rd_valid_n = 1'b0;
            rd_last_n  = 1'b0;
            wr_take    = 1'b0;
            wd_n       = '0;
        end
        if (wr_take) wbuf_n = wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            HADDR      <= '0;
            HTRANS     <= T_IDLE;
            HWRITE     <= 1'b0;
            HSIZE      <= '0;
            HBURST     <= '0;
            HWDATA     <= '0;
            wbuf       <= '0;
            cnt        <= '0;
            dp         <= 1'b0;
            wd         <= '0;
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
            rd_data_o  <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state      <= state_n;
            HADDR      <= haddr_n;
            HTRANS     <= htrans_n;
            HWRITE     <= hwrite_n;
            HSIZE      <= hsize_n;
            HBURST     <= hburst_n;
            HWDATA     <= hwdata_n;
            wbuf       <= wbuf_n;
            cnt        <= cnt_n;
            dp         <= dp_n;
            wd         <= wd_n;
            rd_valid_o <= rd_valid_n;
            rd_last_o  <= rd_last_n;
            rd_data_o  <= rd_data_n;
            done_o     <= done_n;
            err_o      <= err_n;
            timeout_o  <= timeout_n;
        end
    end
endmodule
